// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, state encoding and byte-order helpers for the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Element [0] is the byte at the lowest address (M[a]).
    typedef logic [3:0][7:0] bytes4_t;

    function automatic int dmem_depth(input int rows, input int cols);
        return rows * cols * 4 + cols * 4 + rows * 4;
    endfunction

    function automatic logic [31:0] pack_word(input bytes4_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic bytes4_t unpack_word(input logic [31:0] w);
        bytes4_t b;
        b[0] = w[31:24];
        b[1] = w[23:16];
        b[2] = w[15:8];
        b[3] = w[7:0];
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_byte_array.sv
// ============================================================================
// Module      : dmem_byte_array
// Description : DEPTH x 8 byte storage, 4-byte write port and 4-byte
//               combinational read port starting at any byte address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 76,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  bytes4_t       i_wbytes,
    output bytes4_t       o_rbytes
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i_addr + AW'(i)] <= i_wbytes[i];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_rd_lane
        localparam logic [AW-1:0] c_off = AW'(g);
        assign o_rbytes[g] = r_mem[i_addr + c_off];
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Handshaked word load/store data-memory slave with a
//               configurable read latency. Optional access counters are
//               built when DMEM_ACCESS_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ROWS     = 3,
    parameter int COLS     = 4,
    parameter int READ_LAT = 2
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int          DEPTH      = dmem_depth(ROWS, COLS);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [31:0] c_max_addr = 32'(DEPTH - 4);
    localparam logic [3:0]  c_lat_init = 4'(READ_LAT - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_mem_addr;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_next;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          w_accept;
    logic          w_req_err;
    logic          w_mem_we;
    logic          w_capture;
    logic          w_rsp_fire;
    bytes4_t       w_wbytes;
    bytes4_t       w_rbytes;

    assign w_accept   = req_valid && (r_state == IDLE);
    assign w_req_err  = req_addr > c_max_addr;
    assign w_rsp_fire = (r_state == RESP) && rsp_ready;
    // The acceptance edge addresses memory directly from the request port.
    assign w_mem_addr = (r_state == IDLE) ? req_addr[AW-1:0] : r_addr;
    assign w_wbytes   = unpack_word(req_wdata);

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_err;

    dmem_byte_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (CLOCK_50),
        .i_we     (w_mem_we),
        .i_addr   (w_mem_addr),
        .i_wbytes (w_wbytes),
        .o_rbytes (w_rbytes)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mem_we     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_state_next = RESP;
                    end else if (req_we) begin
                        w_mem_we     = 1'b1;
                        w_state_next = RESP;
                    end else if (READ_LAT == 1) begin
                        w_capture    = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        w_cnt_next   = c_lat_init;
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_capture    = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr  <= req_addr[AW-1:0];
                r_err   <= w_req_err;
                r_rdata <= '0;
            end
            if (w_capture) begin
                r_rdata <= pack_word(w_rbytes);
            end
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    logic        r_we;
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_accept) begin
                r_we <= req_we;
            end
            if (w_rsp_fire && !r_err) begin
                if (r_we && (r_wr_count != 16'hFFFF)) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
                if (!r_we && (r_rd_count != 16'hFFFF)) begin
                    r_rd_count <= r_rd_count + 16'd1;
                end
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

`default_nettype wire
